// File: rtl/pcecd_initiator.sv
// pcecd_initiator: initiator (host) end of the PCE CD drive bus.
// Selects the drive, sends a buffered command block over REQ/ACK and streams
// DATA_IN bytes to the host with backpressure. It then captures STATUS and
// MESSAGE_IN and reports completion once the drive releases BSY.
// Optional build macro: PCECD_INIT_TIMEOUT_EN adds a selection timeout.
// Ports:
//   i_clk, i_rst               clock, async active-high reset
//   i_cmd_wr, i_cmd_byte       command buffer push (IDLE only)
//   i_start, i_bus_reset       transaction start / bus reset request pulses
//   o_busy, o_done, o_error    progress, end pulse, error of last transaction
//   o_status, o_message        captured STATUS / MESSAGE_IN bytes
//   o_data, o_data_valid,
//   i_data_ready               DATA_IN byte stream to the host
//   i_bsy..i_io, i_db          target bus inputs (already synchronous)
//   o_sel, o_ack, o_rst, o_db  initiator bus outputs
module pcecd_initiator #(
    parameter int unsigned CMD_MAX     = 10,
    parameter int unsigned SEL_TIMEOUT = 1024,
    parameter int unsigned RST_CYCLES  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_wr,
    input  logic [7:0] i_cmd_byte,
    input  logic       i_start,
    input  logic       i_bus_reset,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [7:0] o_status,
    output logic [7:0] o_message,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    input  logic       i_data_ready,
    input  logic       i_bsy,
    input  logic       i_req,
    input  logic       i_msg,
    input  logic       i_cd,
    input  logic       i_io,
    input  logic [7:0] i_db,
    output logic       o_sel,
    output logic       o_ack,
    output logic       o_rst,
    output logic [7:0] o_db
);

    localparam int unsigned CNT_W = $clog2(CMD_MAX + 1);
    localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
`ifdef PCECD_INIT_TIMEOUT_EN
    localparam int unsigned TO_W  = $clog2(SEL_TIMEOUT + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PHASE,
        S_WAITREQ,
        S_DONE,
        S_BUSRST
    } state_t;

    state_t             r_state, w_state_nx;
    logic [7:0]         r_buf [CMD_MAX];
    logic [CNT_W-1:0]   r_count, w_count_nx;
    logic [CNT_W-1:0]   r_idx, w_idx_nx;
    logic               r_err_sticky, w_err_sticky_nx;
    logic               r_msg_seen, w_msg_seen_nx;
    logic [RST_W-1:0]   r_rst_cnt, w_rst_cnt_nx;
`ifdef PCECD_INIT_TIMEOUT_EN
    logic [TO_W-1:0]    r_sel_cnt, w_sel_cnt_nx;
`endif
    logic               r_sel, w_sel_nx;
    logic               r_ack, w_ack_nx;
    logic               r_bus_rst, w_bus_rst_nx;
    logic [7:0]         r_db, w_db_nx;
    logic               r_busy, w_busy_nx;
    logic               r_done, w_done_nx;
    logic               r_error, w_error_nx;
    logic [7:0]         r_status, w_status_nx;
    logic [7:0]         r_message, w_message_nx;
    logic [7:0]         r_data, w_data_nx;
    logic               r_data_valid, w_data_valid_nx;
    logic               w_cmd_accept;

    // Command writes land only while idle and the buffer has room.
    assign w_cmd_accept = i_cmd_wr && (r_state == S_IDLE) && (r_count < CNT_W'(CMD_MAX));

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx      = r_state;
        w_count_nx      = r_count;
        w_idx_nx        = r_idx;
        w_err_sticky_nx = r_err_sticky;
        w_msg_seen_nx   = r_msg_seen;
        w_rst_cnt_nx    = r_rst_cnt;
`ifdef PCECD_INIT_TIMEOUT_EN
        w_sel_cnt_nx    = r_sel_cnt;
`endif
        w_sel_nx        = r_sel;
        w_ack_nx        = r_ack;
        w_bus_rst_nx    = r_bus_rst;
        w_db_nx         = r_db;
        w_done_nx       = 1'b0;
        w_error_nx      = r_error;
        w_status_nx     = r_status;
        w_message_nx    = r_message;
        w_data_nx       = r_data;
        w_data_valid_nx = r_data_valid;

        if (w_cmd_accept) begin
            w_count_nx = r_count + CNT_W'(1);
        end

        // Host handshake frees the output byte.
        if (r_data_valid && i_data_ready) begin
            w_data_valid_nx = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (i_bus_reset) begin
                    w_state_nx   = S_BUSRST;
                    w_bus_rst_nx = 1'b1;
                    w_rst_cnt_nx = '0;
                    w_sel_nx     = 1'b0;
                    w_ack_nx     = 1'b0;
                    w_db_nx      = 8'h00;
                    w_count_nx   = '0;
                end else if (i_start && (r_count != '0)) begin
                    w_state_nx      = S_SELECT;
                    w_sel_nx        = 1'b1;
                    w_error_nx      = 1'b0;
                    w_err_sticky_nx = 1'b0;
                    w_msg_seen_nx   = 1'b0;
                    w_idx_nx        = '0;
`ifdef PCECD_INIT_TIMEOUT_EN
                    w_sel_cnt_nx    = '0;
`endif
                end
            end

            S_SELECT: begin
                if (i_bsy) begin
                    w_sel_nx   = 1'b0;
                    w_state_nx = S_PHASE;
                end
`ifdef PCECD_INIT_TIMEOUT_EN
                else if (r_sel_cnt == TO_W'(SEL_TIMEOUT - 1)) begin
                    w_sel_nx   = 1'b0;
                    w_error_nx = 1'b1;
                    w_done_nx  = 1'b1;
                    w_state_nx = S_DONE;
                end else begin
                    w_sel_cnt_nx = r_sel_cnt + TO_W'(1);
                end
`endif
            end

            S_PHASE: begin
                if (!i_bsy) begin
                    w_state_nx = S_DONE;
                    w_done_nx  = 1'b1;
                    w_error_nx = r_err_sticky || !r_msg_seen;
                end else if (i_req) begin
                    case ({i_msg, i_cd, i_io})
                        3'b010: begin
                            // Target asking past the buffered length gets zeros.
                            w_ack_nx   = 1'b1;
                            w_state_nx = S_WAITREQ;
                            if (r_idx < r_count) begin
                                w_db_nx  = r_buf[r_idx];
                                w_idx_nx = r_idx + CNT_W'(1);
                            end else begin
                                w_db_nx         = 8'h00;
                                w_err_sticky_nx = 1'b1;
                            end
                        end
                        3'b001: begin
                            // Stall with ACK low until the host drains the byte.
                            if (!r_data_valid) begin
                                w_data_nx       = i_db;
                                w_data_valid_nx = 1'b1;
                                w_ack_nx        = 1'b1;
                                w_db_nx         = 8'h00;
                                w_state_nx      = S_WAITREQ;
                            end
                        end
                        3'b011: begin
                            w_status_nx = i_db;
                            w_ack_nx    = 1'b1;
                            w_db_nx     = 8'h00;
                            w_state_nx  = S_WAITREQ;
                        end
                        3'b111: begin
                            w_message_nx  = i_db;
                            w_msg_seen_nx = 1'b1;
                            w_ack_nx      = 1'b1;
                            w_db_nx       = 8'h00;
                            w_state_nx    = S_WAITREQ;
                        end
                        default: begin
                            w_ack_nx        = 1'b1;
                            w_db_nx         = 8'h00;
                            w_err_sticky_nx = 1'b1;
                            w_state_nx      = S_WAITREQ;
                        end
                    endcase
                end
            end

            S_WAITREQ: begin
                if (!i_req) begin
                    w_ack_nx   = 1'b0;
                    w_db_nx    = 8'h00;
                    w_state_nx = S_PHASE;
                end
            end

            S_DONE: begin
                w_count_nx = '0;
                w_state_nx = S_IDLE;
            end

            S_BUSRST: begin
                w_data_valid_nx = 1'b0;
                w_count_nx      = '0;
                if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                    w_bus_rst_nx = 1'b0;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_rst_cnt_nx = r_rst_cnt + RST_W'(1);
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_idx        <= '0;
            r_err_sticky <= 1'b0;
            r_msg_seen   <= 1'b0;
            r_rst_cnt    <= '0;
`ifdef PCECD_INIT_TIMEOUT_EN
            r_sel_cnt    <= '0;
`endif
            r_sel        <= 1'b0;
            r_ack        <= 1'b0;
            r_bus_rst    <= 1'b0;
            r_db         <= 8'h00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_status     <= 8'h00;
            r_message    <= 8'h00;
            r_data       <= 8'h00;
            r_data_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_count      <= w_count_nx;
            r_idx        <= w_idx_nx;
            r_err_sticky <= w_err_sticky_nx;
            r_msg_seen   <= w_msg_seen_nx;
            r_rst_cnt    <= w_rst_cnt_nx;
`ifdef PCECD_INIT_TIMEOUT_EN
            r_sel_cnt    <= w_sel_cnt_nx;
`endif
            r_sel        <= w_sel_nx;
            r_ack        <= w_ack_nx;
            r_bus_rst    <= w_bus_rst_nx;
            r_db         <= w_db_nx;
            r_busy       <= w_busy_nx;
            r_done       <= w_done_nx;
            r_error      <= w_error_nx;
            r_status     <= w_status_nx;
            r_message    <= w_message_nx;
            r_data       <= w_data_nx;
            r_data_valid <= w_data_valid_nx;
        end
    end

    // Command byte storage; the count register decides which entries are live.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(CMD_MAX); i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (w_cmd_accept) begin
            r_buf[r_count] <= i_cmd_byte;
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_status     = r_status;
    assign o_message    = r_message;
    assign o_data       = r_data;
    assign o_data_valid = r_data_valid;
    assign o_sel        = r_sel;
    assign o_ack        = r_ack;
    assign o_rst        = r_bus_rst;
    assign o_db         = r_db;

endmodule

// File: tb/tb_pcecd_initiator.sv
module tb_pcecd_initiator;

    localparam int unsigned CMD_MAX     = 10;
    localparam int unsigned SEL_TIMEOUT = 8;
    localparam int unsigned RST_CYCLES  = 16;

    localparam logic [2:0] PH_CMD  = 3'b010;
    localparam logic [2:0] PH_DATA = 3'b001;
    localparam logic [2:0] PH_STAT = 3'b011;
    localparam logic [2:0] PH_MSG  = 3'b111;
    localparam logic [2:0] PH_BAD  = 3'b000;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_cmd_wr = 1'b0;
    logic [7:0] i_cmd_byte = 8'h00;
    logic       i_start = 1'b0;
    logic       i_bus_reset = 1'b0;
    logic       o_busy, o_done, o_error;
    logic [7:0] o_status, o_message, o_data, o_db;
    logic       o_data_valid;
    logic       i_data_ready = 1'b0;
    logic       i_bsy = 1'b0, i_req = 1'b0, i_msg = 1'b0, i_cd = 1'b0, i_io = 1'b0;
    logic [7:0] i_db = 8'h00;
    logic       o_sel, o_ack, o_rst;

    int checks = 0;
    int errors = 0;

    bit ready_hold = 1'b0;
    bit bp_test = 1'b0;

    logic [7:0] wr_q[$];
    logic [7:0] dat_q[$];
    logic [2:0] tq_ph[$];
    logic [7:0] tq_db[$];
    logic [7:0] cap_cmd[$];
    logic [7:0] got_data[$];

    pcecd_initiator #(
        .CMD_MAX(CMD_MAX), .SEL_TIMEOUT(SEL_TIMEOUT), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cmd_wr(i_cmd_wr), .i_cmd_byte(i_cmd_byte),
        .i_start(i_start), .i_bus_reset(i_bus_reset), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_status(o_status), .o_message(o_message), .o_data(o_data),
        .o_data_valid(o_data_valid), .i_data_ready(i_data_ready), .i_bsy(i_bsy),
        .i_req(i_req), .i_msg(i_msg), .i_cd(i_cd), .i_io(i_io), .i_db(i_db),
        .o_sel(o_sel), .o_ack(o_ack), .o_rst(o_rst), .o_db(o_db)
    );

    always #5 clk = ~clk;

    // Host side: random ready; a byte is taken at the next posedge when valid&ready.
    always @(negedge clk) begin
        if (ready_hold) i_data_ready = 1'b0;
        else            i_data_ready = ($urandom_range(0, 3) != 0);
        if (o_data_valid && i_data_ready) got_data.push_back(o_data);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        i_bsy = 0; i_req = 0; i_msg = 0; i_cd = 0; i_io = 0; i_db = 8'h00;
        i_cmd_wr = 0; i_start = 0; i_bus_reset = 0;
        tick(); tick();
        i_rst = 1'b0;
        tick();
    endtask

    // Drive the drive-side target through the phase list in tq_ph/tq_db.
    task automatic run_target();
        int t;
        logic [7:0] db0;
        cap_cmd.delete();
        i_bsy = 1'b1;
        tick();
        checks++;
        if (o_sel !== 1'b0) begin errors++; $display("FAIL sel_drop: o_sel=%0b required 0", o_sel); end
        for (int k = 0; k < tq_ph.size(); k++) begin
            {i_msg, i_cd, i_io} = tq_ph[k];
            i_db = tq_db[k];
            i_req = 1'b1;
            if (bp_test && tq_ph[k] == PH_DATA && o_data_valid) begin
                for (int c = 0; c < 20; c++) begin
                    tick();
                    checks++;
                    if (o_ack !== 1'b0 || o_data_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_stall: cycle %0d ack=%0b valid=%0b required ack 0 valid 1", c, o_ack, o_data_valid);
                    end
                end
                ready_hold = 1'b0;
                bp_test = 1'b0;
            end
            t = 0;
            tick();
            while (o_ack !== 1'b1 && t < 200) begin tick(); t++; end
            checks++;
            if (o_ack !== 1'b1) begin
                errors++;
                $display("FAIL ack_timeout: item %0d ack=%0b required 1", k, o_ack);
                i_req = 1'b0; i_bsy = 1'b0;
                return;
            end
            if (tq_ph[k] != PH_DATA) begin
                checks++;
                if (t != 0) begin errors++; $display("FAIL ack_latency: item %0d extra cycles %0d required 0", k, t); end
            end
            if (tq_ph[k] == PH_CMD) cap_cmd.push_back(o_db);
            if (tq_ph[k] == PH_DATA) begin
                checks++;
                if (o_data_valid !== 1'b1 || o_data !== tq_db[k]) begin
                    errors++;
                    $display("FAIL data_latch: valid=%0b data=%02h required 1/%02h", o_data_valid, o_data, tq_db[k]);
                end
            end
            db0 = o_db;
            repeat ($urandom_range(0, 2)) tick();
            checks++;
            if (o_db !== db0 || o_ack !== 1'b1) begin
                errors++;
                $display("FAIL db_stable: db=%02h ack=%0b required %02h/1", o_db, o_ack, db0);
            end
            i_req = 1'b0;
            tick();
            checks++;
            if (o_ack !== 1'b0) begin errors++; $display("FAIL ack_fall: ack=%0b required 0", o_ack); end
        end
        i_bsy = 1'b0;
        {i_msg, i_cd, i_io} = 3'b000;
        i_db = 8'h00;
    endtask

    // One full transaction with expectations taken from the bus rules.
    task automatic run_txn(input int n_req, input logic [7:0] st, input logic [7:0] mg,
                           input bit has_msg, input bit has_bad, input string name);
        int t;
        int exp_len;
        bit exp_err;
        logic [7:0] exp_b;
        exp_len = (wr_q.size() < CMD_MAX) ? wr_q.size() : CMD_MAX;
        exp_err = (n_req > exp_len) || has_bad || !has_msg;
        foreach (wr_q[i]) begin
            i_cmd_wr = 1'b1; i_cmd_byte = wr_q[i]; tick();
        end
        i_cmd_wr = 1'b0;
        got_data.delete();
        i_start = 1'b1; tick(); i_start = 1'b0;
        checks++;
        if (o_sel !== 1'b1 || o_busy !== 1'b1) begin
            errors++; $display("FAIL %s sel_rise: sel=%0b busy=%0b required 1/1", name, o_sel, o_busy);
        end
        tq_ph.delete(); tq_db.delete();
        for (int i = 0; i < n_req; i++) begin tq_ph.push_back(PH_CMD); tq_db.push_back(8'($urandom)); end
        if (has_bad) begin tq_ph.push_back(PH_BAD); tq_db.push_back(8'($urandom)); end
        foreach (dat_q[i]) begin tq_ph.push_back(PH_DATA); tq_db.push_back(dat_q[i]); end
        tq_ph.push_back(PH_STAT); tq_db.push_back(st);
        if (has_msg) begin tq_ph.push_back(PH_MSG); tq_db.push_back(mg); end
        run_target();
        t = 0; tick();
        while (o_done !== 1'b1 && t < 20) begin tick(); t++; end
        checks++;
        if (o_done !== 1'b1 || o_error !== exp_err) begin
            errors++; $display("FAIL %s done: done=%0b err=%0b required 1/%0b", name, o_done, o_error, exp_err);
        end
        checks++;
        if (o_status !== st || (has_msg && o_message !== mg)) begin
            errors++; $display("FAIL %s capture: status=%02h msg=%02h required %02h/%02h", name, o_status, o_message, st, mg);
        end
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_error !== exp_err) begin
            errors++; $display("FAIL %s idle: done=%0b busy=%0b err=%0b required 0/0/%0b", name, o_done, o_busy, o_error, exp_err);
        end
        checks++;
        if (cap_cmd.size() != n_req) begin
            errors++; $display("FAIL %s cmd_count: got %0d required %0d", name, cap_cmd.size(), n_req);
        end else begin
            foreach (cap_cmd[i]) begin
                exp_b = (i < exp_len) ? wr_q[i] : 8'h00;
                checks++;
                if (cap_cmd[i] !== exp_b) begin
                    errors++; $display("FAIL %s cmd_byte%0d: got %02h required %02h", name, i, cap_cmd[i], exp_b);
                end
            end
        end
        if (ready_hold) begin
            checks++;
            if (got_data.size() != 0 || o_data_valid !== (dat_q.size() != 0)) begin
                errors++; $display("FAIL %s held_data: taken %0d valid=%0b", name, got_data.size(), o_data_valid);
            end
        end else begin
            t = 0;
            while (o_data_valid === 1'b1 && t < 100) begin tick(); t++; end
            checks++;
            if (got_data.size() != dat_q.size()) begin
                errors++; $display("FAIL %s data_count: got %0d required %0d", name, got_data.size(), dat_q.size());
            end else begin
                foreach (dat_q[i]) begin
                    checks++;
                    if (got_data[i] !== dat_q[i]) begin
                        errors++; $display("FAIL %s data%0d: got %02h required %02h", name, i, got_data[i], dat_q[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick(); tick();
        checks++;
        if ({o_busy, o_done, o_error, o_status, o_message, o_data, o_data_valid, o_sel, o_ack, o_rst, o_db} !== '0) begin
            errors++; $display("FAIL reset_values: busy=%0b sel=%0b ack=%0b rst=%0b db=%02h", o_busy, o_sel, o_ack, o_rst, o_db);
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_full_command();
        wr_q = '{8'h08, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00};
        dat_q = '{8'hA5, 8'h5A, 8'hFF};
        run_txn(6, 8'h00, 8'h00, 1'b1, 1'b0, "full_cmd");
    endtask

    task automatic test_backpressure();
        wr_q = '{8'h28, 8'h01};
        dat_q = '{8'h11, 8'h22, 8'h33};
        ready_hold = 1'b1;
        bp_test = 1'b1;
        run_txn(2, 8'h02, 8'h00, 1'b1, 1'b0, "backpressure");
        ready_hold = 1'b0;
        bp_test = 1'b0;
    endtask

    task automatic test_cmd_overrun();
        wr_q = '{8'($urandom), 8'($urandom)};
        dat_q.delete();
        run_txn(3, 8'h00, 8'h00, 1'b1, 1'b0, "overrun");
    endtask

    task automatic test_buffer_full();
        // Twelve writes: only CMD_MAX are kept, the eleventh request is padded.
        wr_q.delete();
        for (int i = 0; i < 12; i++) wr_q.push_back(8'($urandom));
        dat_q.delete();
        run_txn(CMD_MAX + 1, 8'h00, 8'h00, 1'b1, 1'b0, "buf_full");
    endtask

    task automatic test_random();
        int nw, nr, nd;
        bit has_msg, has_bad;
        for (int it = 0; it < 8; it++) begin
            nw = $urandom_range(1, 12);
            wr_q.delete(); dat_q.delete();
            for (int i = 0; i < nw; i++) wr_q.push_back(8'($urandom));
            nr = ((nw < CMD_MAX) ? nw : CMD_MAX) + (($urandom_range(0, 3) == 0) ? 1 : 0);
            nd = $urandom_range(0, 4);
            for (int i = 0; i < nd; i++) dat_q.push_back(8'($urandom));
            has_msg = ($urandom_range(0, 3) != 0);
            has_bad = ($urandom_range(0, 4) == 0);
            run_txn(nr, 8'($urandom), 8'($urandom), has_msg, has_bad, "random");
        end
    endtask

    task automatic test_bus_reset();
        int n;
        bit bad;
        // Leave one DATA_IN byte unconsumed so the reset has something to discard.
        wr_q = '{8'h12};
        dat_q = '{8'h77};
        ready_hold = 1'b1;
        run_txn(1, 8'h00, 8'h00, 1'b1, 1'b0, "pending");
        wr_q = '{8'h01, 8'h02, 8'h03};
        foreach (wr_q[i]) begin i_cmd_wr = 1'b1; i_cmd_byte = wr_q[i]; tick(); end
        i_cmd_wr = 1'b0;
        i_bus_reset = 1'b1; i_start = 1'b1; tick();
        i_bus_reset = 1'b0; i_start = 1'b0;
        n = 0; bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (o_rst) n++;
            if (o_sel || o_done) bad = 1'b1;
            tick();
        end
        checks++;
        if (n != RST_CYCLES || bad) begin
            errors++; $display("FAIL bus_reset_pulse: rst cycles %0d sel/done seen %0b required %0d/0", n, bad, RST_CYCLES);
        end
        checks++;
        if (o_data_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL bus_reset_discard: valid=%0b busy=%0b required 0/0", o_data_valid, o_busy);
        end
        ready_hold = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        checks++;
        if (o_sel !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL bus_reset_empty: sel=%0b busy=%0b required 0/0", o_sel, o_busy);
        end
    endtask

    task automatic test_sel_timeout();
        int n;
        i_cmd_wr = 1'b1; i_cmd_byte = 8'h00; tick(); i_cmd_wr = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
`ifdef PCECD_INIT_TIMEOUT_EN
        n = 0;
        while (o_sel === 1'b1 && n < 50) begin n++; tick(); end
        checks++;
        if (n != SEL_TIMEOUT || o_done !== 1'b1 || o_error !== 1'b1) begin
            errors++; $display("FAIL sel_timeout: sel cycles %0d done=%0b err=%0b required %0d/1/1", n, o_done, o_error, SEL_TIMEOUT);
        end
`else
        n = 0;
        repeat (100) begin if (o_sel === 1'b1) n++; tick(); end
        checks++;
        if (n != 100 || o_sel !== 1'b1) begin
            errors++; $display("FAIL sel_wait: sel high %0d of 100 cycles, sel=%0b required 100/1", n, o_sel);
        end
`endif
        apply_reset();
    endtask

    task automatic test_async_reset();
        i_cmd_wr = 1'b1; i_cmd_byte = 8'h5C; tick(); i_cmd_wr = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        i_bsy = 1'b1; tick();
        {i_msg, i_cd, i_io} = PH_CMD; i_req = 1'b1; tick();
        checks++;
        if (o_ack !== 1'b1 || o_db !== 8'h5C) begin
            errors++; $display("FAIL async_setup: ack=%0b db=%02h required 1/5c", o_ack, o_db);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if (o_ack !== 1'b0 || o_busy !== 1'b0 || o_sel !== 1'b0 || o_db !== 8'h00) begin
            errors++; $display("FAIL async_reset: ack=%0b busy=%0b sel=%0b db=%02h required 0/0/0/00", o_ack, o_busy, o_sel, o_db);
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_full_command();
        test_backpressure();
        test_cmd_overrun();
        test_buffer_full();
        test_random();
        test_bus_reset();
        test_sel_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcecd_initiator.md
# pcecd_initiator

Initiator (host) end of the PCE CD drive bus. It selects the drive, sends a command block of up to `CMD_MAX` bytes over the REQ/ACK handshake, and streams DATA_IN bytes out to the host side with backpressure. It then captures the STATUS and MESSAGE_IN bytes and reports completion once the drive releases the bus. It sits between the CD interface register file and the drive-side target, and drives the SEL, ACK and RST signals that the target samples.

## Interface
- `CMD_MAX`, 10: command buffer depth in bytes (max 15).
- `SEL_TIMEOUT`, 1024: cycles to wait for BSY after SEL is asserted.
- `RST_CYCLES`, 16: width of the bus reset pulse, in cycles.

- `i_clk`  in  1  sole clock; all logic on its posedge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_cmd_wr`  in  1  push `i_cmd_byte` into the command buffer.
- `i_cmd_byte`  in  8  command byte.
- `i_start`  in  1  one-cycle pulse that begins a transaction.
- `i_bus_reset`  in  1  one-cycle pulse that requests a bus reset.
- `o_busy`  out  1  transaction or bus reset in progress.
- `o_done`  out  1  one-cycle pulse at transaction end.
- `o_error`  out  1  error flag for the last transaction; valid while `o_done`=1 and held until the next `i_start`.
- `o_status`  out  8  captured STATUS byte.
- `o_message`  out  8  captured MESSAGE_IN byte.
- `o_data`  out  8  DATA_IN byte.
- `o_data_valid`  out  1  `o_data` holds an unconsumed byte.
- `i_data_ready`  in  1  host consumes `o_data` when `o_data_valid` and `i_data_ready` are both 1.
- `i_bsy`, `i_req`, `i_msg`, `i_cd`, `i_io`  in  1 each  target bus signals, already synchronous to `i_clk`.
- `i_db`  in  8  target data bus.
- `o_sel`, `o_ack`, `o_rst`  out  1 each  initiator bus signals.
- `o_db`  out  8  initiator data bus.

## Operation
- Reset values: every output 0, state IDLE, buffer empty.
- Command buffer:
  - `i_cmd_wr` is accepted only in IDLE when fewer than `CMD_MAX` bytes are held; otherwise the write is dropped.
  - The buffer count is the command length. The buffer is cleared at DONE and by a bus reset.
- **IDLE**:
  - `i_start` with count>0 → SELECT, `o_sel`=1, `o_error` cleared.
  - `i_start` with count 0 is ignored.
  - `i_bus_reset` → BUSRST. It has priority over `i_start` in the same cycle.
- **SELECT**: `i_bsy`=1 → `o_sel`=0, go to PHASE.
- **PHASE**: while `i_bsy`=1 and `i_req`=1, decode {msg,cd,io}:
  - COMMAND (0,1,0):
    - `o_db` = buf[idx], `o_ack`=1, idx++.
    - When idx ≥ count, drive 0x00 and set a sticky error.
  - DATA_IN (0,0,1): only if `o_data_valid`=0, latch `i_db` into `o_data`, set valid, `o_ack`=1. Otherwise stall with ACK low.
  - STATUS (0,1,1): latch `i_db` into `o_status`, `o_ack`=1.
  - MESSAGE_IN (1,1,1): latch `i_db` into `o_message`, `o_ack`=1, set the msg-seen flag.
  - Any other encoding: `o_ack`=1 without acting on the data, set sticky error.
  - After any ACK → WAITREQ.
- **WAITREQ**: hold `o_ack` and `o_db` until `i_req`=0, then `o_ack`=0 → PHASE.
- **Bus free**: `i_bsy`=0 in PHASE → DONE. `o_error` = sticky error OR (msg-seen=0).
- **DONE**: `o_done`=1 for one cycle, clear the buffer → IDLE.
- **BUSRST**:
  - `o_rst`=1 for exactly `RST_CYCLES` cycles, all other bus outputs 0 → IDLE.
  - Pending `o_data` is discarded.
  - `o_done` is not pulsed.
- `o_busy`=1 in every state except IDLE.

## Timing
- `o_sel` rises the cycle after `i_start`.
- `o_ack` rises one cycle after `i_req`=1 is sampled in PHASE, and falls one cycle after `i_req`=0 is sampled.
- `o_db` is stable from the cycle ACK rises until ACK falls.
- `o_data`/`o_data_valid` update in the same cycle that ACK rises.
- Valid clears in the cycle after the handshake.
- A new DATA_IN ACK is possible in the cycle after valid clears.
- `i_rst` mid-transaction forces reset values immediately; `o_sel`, `o_ack` and `o_rst` drop asynchronously.

## Configuration
- `PCECD_INIT_TIMEOUT_EN`
  - Defined: SELECT counts cycles. After `SEL_TIMEOUT` cycles without `i_bsy`, drop `o_sel`, set error, go to DONE.
  - Undefined: SELECT waits indefinitely and the counter is not synthesized.

## Test plan
- **Full command and read**:
  - Stimulus: load 6 bytes 0x08,0x00,0x00,0x10,0x01,0x00 and start; the target walks COMMAND(6) → DATA_IN(3 bytes A5,5A,FF) → STATUS 0x00 → MSG 0x00 → bus free.
  - Response: 6 ACKs carrying exactly those bytes; `o_data` A5,5A,FF; `o_status`=0x00; `o_message`=0x00; `o_done` once with `o_error`=0.
- **Data backpressure**: `i_data_ready`=0 for 20 cycles during DATA_IN → `o_ack` stays 0 while valid=1; exactly one byte is lost-free per ACK.
- **Command overrun**: load 2 bytes; the target requests 3 → third `o_db`=0x00; `o_done` with `o_error`=1.
- **Selection timeout**:
  - With the macro and `SEL_TIMEOUT`=8, `i_bsy` held at 0 → `o_sel` high for 8 cycles, then `o_done` with `o_error`=1.
  - Without the macro, `o_sel` is still high after 100 cycles.
- **Bus reset**: `i_bus_reset` together with `i_start` → `o_rst`=1 for exactly 16 cycles, no `o_sel`, no `o_done`, buffer empty afterward.
- **Async reset**: assert `i_rst` mid-WAITREQ → `o_ack`=0 and `o_busy`=0 before the next clock edge.
